output_port_vc_multi_credit_counter: RTL

//  Per-VC credit tracker for a router output port, next generation of the single-lane credit counter.

---
 rtl/noc_credit_pkg.sv | 22 ++
 rtl/std_dffrve.sv | 25 ++
 rtl/vc_credit_slice.sv | 102 ++++++++++
 rtl/output_port_vc_multi_credit_counter.sv | 90 +++++++++
 4 files changed

// File: rtl/noc_credit_pkg.sv
// Shared helpers for the output-port VC credit counter.
//   idx_w    : VC id width (at least 1 bit).
//   cnt_w    : counter width able to hold 0..depth.
//   popcount : number of set bits in a vector of up to 32 lanes.
package noc_credit_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int b = 0; b < 32; b++) c += int'(v[b]);
        return c;
    endfunction

endpackage

// File: rtl/std_dffrve.sv
// Generic register with async active-low reset to RST_VAL and a load enable.
//   clk, rstn : clock, async active-low reset
//   i_en      : load enable, holds when low
//   i_d / o_q : data in / registered data out
module std_dffrve #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     r_q <= RST_VAL;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/vc_credit_slice.sv
// Credit counter for one VC: applies inc/dec counts, clamps to [0, VC_DEPTH],
// and registers avail/full from the same next-state value as the counter.
// Optional sticky overflow/underflow flags when CREDIT_ERR_CHK_EN is defined.
//   clk, rstn  : clock, async active-low reset
//   i_inc      : number of credit returns hitting this VC this cycle
//   i_dec      : number of credit consumptions hitting this VC this cycle
//   o_cnt      : current credit count
//   o_avail    : count != 0
//   o_full     : count == VC_DEPTH
//   i_err_clr  : clear sticky errors        (CREDIT_ERR_CHK_EN only)
//   o_ovf/o_unf: sticky overflow/underflow  (CREDIT_ERR_CHK_EN only)
module vc_credit_slice #(
    parameter int VC_DEPTH = 4,
    parameter int W        = 3,
    parameter int INC_W    = 2,
    parameter int DEC_W    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [INC_W-1:0] i_inc,
    input  logic [DEC_W-1:0] i_dec,
    output logic [W-1:0]     o_cnt,
    output logic             o_avail,
    output logic             o_full
`ifdef CREDIT_ERR_CHK_EN
    ,
    input  logic             i_err_clr,
    output logic             o_ovf,
    output logic             o_unf
`endif
);

    // Signed working width: widest operand plus sign and carry headroom.
    localparam int MW = (W > INC_W) ? ((W > DEC_W) ? W : DEC_W)
                                    : ((INC_W > DEC_W) ? INC_W : DEC_W);
    localparam int SW = MW + 2;
    localparam logic signed [SW-1:0] DEPTH_S = SW'(VC_DEPTH);
    localparam logic        [W-1:0]  DEPTH_W = W'(VC_DEPTH);

    logic [W-1:0]           w_q;
    logic [W-1:0]           w_d;
    logic signed [SW-1:0]   w_sum;
    logic                   w_ovf;
    logic                   w_unf;
    logic                   w_en;
    logic                   r_avail;
    logic                   r_full;

    assign w_sum = $signed(SW'(w_q)) + $signed(SW'(i_inc)) - $signed(SW'(i_dec));
    assign w_ovf = (w_sum > DEPTH_S);
    assign w_unf = w_sum[SW-1];
    assign w_d   = w_ovf ? DEPTH_W : (w_unf ? '0 : w_sum[W-1:0]);
    // Equal inc/dec without clamping leaves the count unchanged; skip the load.
    assign w_en  = (SW'(i_inc) != SW'(i_dec)) || w_ovf || w_unf;

    std_dffrve #(
        .WIDTH   (W),
        .RST_VAL (DEPTH_W)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .i_en (w_en),
        .i_d  (w_d),
        .o_q  (w_q)
    );

    // w_d equals w_q whenever w_en is low, so flopping w_d every cycle keeps
    // the flags in lockstep with the counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_avail <= 1'b1;
            r_full  <= 1'b1;
        end else begin
            r_avail <= (w_d != '0);
            r_full  <= (w_d == DEPTH_W);
        end
    end

    assign o_cnt   = w_q;
    assign o_avail = r_avail;
    assign o_full  = r_full;

`ifdef CREDIT_ERR_CHK_EN
    logic r_ovf;
    logic r_unf;

    // Clear drops only the prior value; an event in the clear cycle re-sets.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~i_err_clr) | w_ovf;
            r_unf <= (r_unf & ~i_err_clr) | w_unf;
        end
    end

    assign o_ovf = r_ovf;
    assign o_unf = r_unf;
`endif

endmodule

// File: rtl/output_port_vc_multi_credit_counter.sv
// Per-VC credit tracker for a router output port with multiple credit-return
// and credit-consume lanes per cycle. Decodes each lane to its VC, counts hits
// per VC and hands the counts to one vc_credit_slice per VC.
// Optional feature macro: CREDIT_ERR_CHK_EN (sticky ovf/unf flags + clear).
//   clk, rstn           : clock, async active-low reset
//   free_vld_i/_vc_id_i : credit-return lanes, lane k id at [k*IDX_W+:IDX_W]
//   consume_vld_i/_vc_id_i : credit-consume lanes
//   vc_credit_counter_o : per-VC credits, VC i at [i*W+:W]
//   vc_credit_avail_o   : registered count != 0
//   vc_credit_full_o    : registered count == VC_DEPTH
//   credit_err_clr_i, credit_ovf_o, credit_unf_o : macro only
// Lane counts up to 32 are supported by the popcount helper.
module output_port_vc_multi_credit_counter
    import noc_credit_pkg::*;
#(
    parameter int VC_NUM             = 4,
    parameter int VC_NUM_IDX_W       = idx_w(VC_NUM),
    parameter int VC_DEPTH           = 4,
    parameter int VC_DEPTH_COUNTER_W = cnt_w(VC_DEPTH),
    parameter int FREE_PORT_NUM      = 2,
    parameter int CONSUME_PORT_NUM   = 1
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [FREE_PORT_NUM-1:0]               free_vld_i,
    input  logic [FREE_PORT_NUM*VC_NUM_IDX_W-1:0]  free_vc_id_i,
    input  logic [CONSUME_PORT_NUM-1:0]            consume_vld_i,
    input  logic [CONSUME_PORT_NUM*VC_NUM_IDX_W-1:0] consume_vc_id_i,
    output logic [VC_NUM*VC_DEPTH_COUNTER_W-1:0]   vc_credit_counter_o,
    output logic [VC_NUM-1:0]                      vc_credit_avail_o,
    output logic [VC_NUM-1:0]                      vc_credit_full_o
`ifdef CREDIT_ERR_CHK_EN
    ,
    input  logic                                   credit_err_clr_i,
    output logic [VC_NUM-1:0]                      credit_ovf_o,
    output logic [VC_NUM-1:0]                      credit_unf_o
`endif
);

    localparam int W       = VC_DEPTH_COUNTER_W;
    localparam int FREE_CW = cnt_w(FREE_PORT_NUM);
    localparam int CONS_CW = cnt_w(CONSUME_PORT_NUM);

    genvar gi, gk;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            localparam logic [VC_NUM_IDX_W-1:0] VID = VC_NUM_IDX_W'(gi);

            logic [FREE_PORT_NUM-1:0]    w_free_hit;
            logic [CONSUME_PORT_NUM-1:0] w_cons_hit;
            logic [FREE_CW-1:0]          w_inc;
            logic [CONS_CW-1:0]          w_dec;

            // Ids >= VC_NUM match no slice and are dropped here.
            for (gk = 0; gk < FREE_PORT_NUM; gk++) begin : g_free
                assign w_free_hit[gk] = free_vld_i[gk] &&
                    (free_vc_id_i[gk*VC_NUM_IDX_W +: VC_NUM_IDX_W] == VID);
            end
            for (gk = 0; gk < CONSUME_PORT_NUM; gk++) begin : g_cons
                assign w_cons_hit[gk] = consume_vld_i[gk] &&
                    (consume_vc_id_i[gk*VC_NUM_IDX_W +: VC_NUM_IDX_W] == VID);
            end

            assign w_inc = FREE_CW'(popcount(32'(w_free_hit)));
            assign w_dec = CONS_CW'(popcount(32'(w_cons_hit)));

            vc_credit_slice #(
                .VC_DEPTH (VC_DEPTH),
                .W        (W),
                .INC_W    (FREE_CW),
                .DEC_W    (CONS_CW)
            ) u_slice (
                .clk       (clk),
                .rstn      (rstn),
                .i_inc     (w_inc),
                .i_dec     (w_dec),
                .o_cnt     (vc_credit_counter_o[gi*W +: W]),
                .o_avail   (vc_credit_avail_o[gi]),
                .o_full    (vc_credit_full_o[gi])
`ifdef CREDIT_ERR_CHK_EN
                ,
                .i_err_clr (credit_err_clr_i),
                .o_ovf     (credit_ovf_o[gi]),
                .o_unf     (credit_unf_o[gi])
`endif
            );
        end
    endgenerate

endmodule
